// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared processor<->memory bus between instruction prefetch and the LSQ,
// and routes each returning tag back to the requester that owns it.
module mem_bus_arbiter #(
    parameter int XLEN          = 32,
    parameter int STARVE_LIMIT  = 4,
    parameter int MAX_FETCH_OUT = 4,
    parameter int NUM_TAGS      = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    input  logic            take_branch,
    output logic            fetch_accepted,
    output logic            fetch_rvalid,
    output logic [63:0]     fetch_rdata,
    input  logic            data_req,
    input  logic [1:0]      data_cmd,
    input  logic [XLEN-1:0] data_addr,
    input  logic [63:0]     data_wdata,
    output logic            data_accepted,
    output logic            data_rvalid,
    output logic [63:0]     data_rdata,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [0:0]      debug_state
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [0:0] DATA_PRI    = 1'b0;
    localparam logic [0:0] FETCH_FORCE = 1'b1;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(NUM_TAGS + 1);

    logic [0:0]          state, state_nxt;
    logic [SW-1:0]       starve_cnt, starve_nxt;
    logic [NUM_TAGS-1:0] tag_valid, tag_owner, tag_squash;
    logic [NUM_TAGS-1:0] valid_nxt, owner_nxt, squash_nxt;
    logic [CW-1:0]       fetch_out_cnt;
    logic                fetch_elig, sel_fetch, sel_data, ret_hit, alloc;

    // Outstanding fetches are derived from the table so the count can never drift from it.
    always_comb begin
        fetch_out_cnt = '0;
        for (int i = 1; i < NUM_TAGS; i++) begin
            fetch_out_cnt = fetch_out_cnt + CW'(tag_valid[i] && !tag_owner[i] && !tag_squash[i]);
        end
    end

    assign fetch_elig = fetch_req && (fetch_out_cnt < CW'(MAX_FETCH_OUT)) && !take_branch;

    always_comb begin
        sel_fetch = 1'b0;
        sel_data  = 1'b0;
        if (!reset) begin
            if (state == FETCH_FORCE) begin
                sel_fetch = fetch_elig;
                sel_data  = data_req && !fetch_elig;
            end else begin
                sel_data  = data_req;
                sel_fetch = fetch_elig && !data_req;
            end
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (sel_fetch) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = fetch_addr;
        end else if (sel_data) begin
            proc2mem_command = data_cmd;
            proc2mem_addr    = data_addr;
            proc2mem_data    = (data_cmd == BUS_STORE) ? data_wdata : 64'd0;
        end
    end

    assign fetch_accepted = sel_fetch && (mem2proc_response != 4'd0);
    assign data_accepted  = sel_data && (mem2proc_response != 4'd0);
    assign alloc          = fetch_accepted || (data_accepted && data_cmd == BUS_LOAD);

    assign ret_hit      = !reset && (mem2proc_tag != 4'd0) && tag_valid[mem2proc_tag];
    assign data_rvalid  = ret_hit && tag_owner[mem2proc_tag];
    assign fetch_rvalid = ret_hit && !tag_owner[mem2proc_tag] && !tag_squash[mem2proc_tag];
    assign data_rdata   = data_rvalid ? mem2proc_data : 64'd0;
    assign fetch_rdata  = fetch_rvalid ? mem2proc_data : 64'd0;
    assign debug_state  = state;

    // Squash, then retire the returning tag, then allocate: a tag reused this cycle keeps its new owner.
    always_comb begin
        valid_nxt  = tag_valid;
        owner_nxt  = tag_owner;
        squash_nxt = tag_squash;
        if (take_branch) begin
            squash_nxt = squash_nxt | (tag_valid & ~tag_owner);
        end
        if (ret_hit) begin
            valid_nxt[mem2proc_tag]  = 1'b0;
            owner_nxt[mem2proc_tag]  = 1'b0;
            squash_nxt[mem2proc_tag] = 1'b0;
        end
        if (alloc) begin
            valid_nxt[mem2proc_response]  = 1'b1;
            owner_nxt[mem2proc_response]  = data_accepted;
            squash_nxt[mem2proc_response] = 1'b0;
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (fetch_accepted || !fetch_req) begin
            starve_nxt = '0;
        end else if (fetch_elig && !sel_fetch && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + SW'(1);
        end
        state_nxt = state;
        if (state == DATA_PRI) begin
            if (starve_nxt == SW'(STARVE_LIMIT)) state_nxt = FETCH_FORCE;
        end else if (fetch_accepted || !fetch_req) begin
            state_nxt = DATA_PRI;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= DATA_PRI;
            starve_cnt <= '0;
            tag_valid  <= '0;
            tag_owner  <= '0;
            tag_squash <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tag_valid  <= valid_nxt;
            tag_owner  <= owner_nxt;
            tag_squash <= squash_nxt;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and random stimulus for mem_bus_arbiter; expected bus activity is predicted by a
// tag-ownership model and checked by an independent negedge monitor.
module tb_mem_bus_arbiter;

    localparam int W = 231;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0, take_branch = 1'b0, data_req = 1'b0;
    logic [31:0] fetch_addr = '0, data_addr = '0;
    logic [1:0]  data_cmd = '0;
    logic [63:0] data_wdata = '0, mem2proc_data = '0;
    logic [3:0]  mem2proc_response = '0, mem2proc_tag = '0;
    logic        fetch_accepted, fetch_rvalid, data_accepted, data_rvalid;
    logic [63:0] fetch_rdata, data_rdata, proc2mem_data;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [0:0]  debug_state;

    mem_bus_arbiter #(.XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .take_branch(take_branch),
        .fetch_accepted(fetch_accepted), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_cmd(data_cmd), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_accepted(data_accepted), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag), .debug_state(debug_state)
    );

    always #5 clock = ~clock;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: tag -> owner (0 live fetch, 1 data, 2 squashed fetch).
    int owner_of[int];
    int streak = 0;
    bit forced = 1'b0;

    task automatic drive(input bit freq, input logic [31:0] faddr, input bit tb,
                         input bit dreq, input logic [1:0] dcmd, input logic [31:0] daddr,
                         input logic [63:0] dwd, input logic [3:0] resp,
                         input logic [3:0] rtag, input logic [63:0] rdat);
        int outn;
        bit elig, sf, sd, fa, da, frv, drv;
        logic [1:0] cmd;
        logic [31:0] a;
        logic [63:0] pd;
        logic [W-1:0] e;
        @(posedge clock);
        #1;
        reset = 1'b0;
        fetch_req = freq; fetch_addr = faddr; take_branch = tb;
        data_req = dreq; data_cmd = dcmd; data_addr = daddr; data_wdata = dwd;
        mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdat;
        outn = 0;
        foreach (owner_of[k]) if (owner_of[k] == 0) outn++;
        elig = freq && outn < 4 && !tb;
        if (forced) begin
            sf = elig; sd = dreq && !elig;
        end else begin
            sd = dreq; sf = elig && !dreq;
        end
        cmd = 2'd0; a = '0; pd = '0;
        if (sf) begin
            cmd = 2'd1; a = faddr;
        end else if (sd) begin
            cmd = dcmd; a = daddr; pd = (dcmd == 2'd2) ? dwd : 64'd0;
        end
        fa = sf && resp != 0;
        da = sd && resp != 0;
        frv = 1'b0; drv = 1'b0;
        if (rtag != 0 && owner_of.exists(int'(rtag))) begin
            drv = owner_of[int'(rtag)] == 1;
            frv = owner_of[int'(rtag)] == 0;
        end
        e = {forced, cmd, a, pd, fa, da, frv, frv ? rdat : 64'd0, drv, drv ? rdat : 64'd0};
        if (cmd != 2'd0 || frv || drv) exp_q.push_back(e);
        if (tb) foreach (owner_of[k]) if (owner_of[k] == 0) owner_of[k] = 2;
        if (rtag != 0 && owner_of.exists(int'(rtag))) owner_of.delete(int'(rtag));
        if (fa) owner_of[int'(resp)] = 0;
        else if (da && dcmd == 2'd1) owner_of[int'(resp)] = 1;
        if (fa || !freq) streak = 0;
        else if (elig && !sf) streak++;
        if (!forced && streak >= 4) forced = 1'b1;
        else if (forced && (fa || !freq)) forced = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            reset = 1'b1;
            fetch_req = 1'($urandom); data_req = 1'($urandom); take_branch = 1'b0;
            data_cmd = 2'd1; mem2proc_response = 4'($urandom_range(1, 15));
            mem2proc_tag = 4'($urandom_range(0, 15)); mem2proc_data = {$urandom, $urandom};
        end
        owner_of.delete();
        streak = 0;
        forced = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ret(input logic [3:0] t, input logic [63:0] d);
        drive(0, 0, 0, 0, 0, 0, 0, 0, t, d);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [3:0] r);
        drive(1, addr, 0, 0, 0, 0, 0, r, 0, 0);
    endtask

    // Monitor: outputs must be quiet in reset; any bus activity must match the next expectation.
    always @(negedge clock) begin
        logic [W-1:0] act, e;
        act = {debug_state, proc2mem_command, proc2mem_addr, proc2mem_data, fetch_accepted,
               data_accepted, fetch_rvalid, fetch_rdata, data_rvalid, data_rdata};
        if (reset) begin
            n_cmp++;
            if (act != '0) begin
                n_fail++;
                $display("FAIL reset_out: got %h want 0", act);
            end
        end else if (proc2mem_command != 2'd0 || fetch_rvalid || data_rvalid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_txn @%0t: got %h want nothing", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (e != act) begin
                    n_fail++;
                    $display("FAIL txn @%0t: got %h want %h", $time, act, e);
                end
            end
        end
    end

    initial begin
        do_reset(3);
        // Lone fetch and its return.
        fetch(32'h100, 4'd3);
        idle();
        ret(4'd3, 64'hDEAD_BEEF_0000_0003);
        // Starvation: data wins four cycles, fetch forced on the fifth, data again on the sixth.
        for (int i = 0; i < 6; i++)
            drive(1, 32'h180, 0, 1, 2'd2, 32'h2000 + 32'(i * 8), {32'hA5A5, 32'(i)}, 4'(4 + i), 0, 0);
        ret(4'd8, 64'h8888);
        // Fetch outstanding limit.
        for (int i = 1; i <= 4; i++) fetch(32'h200 + 32'(i * 8), 4'(i));
        fetch(32'h240, 4'd5);
        drive(1, 32'h240, 0, 1, 2'd1, 32'h1000, 0, 4'd10, 0, 0);
        drive(1, 32'h240, 0, 0, 0, 0, 0, 4'd5, 4'd2, 64'h2222);
        fetch(32'h240, 4'd11);
        ret(4'd1, 64'h1111); ret(4'd3, 64'h3333); ret(4'd4, 64'h4444);
        ret(4'd11, 64'hBBBB); ret(4'd10, 64'hAAAA);
        // Branch squash.
        fetch(32'h300, 4'd5);
        fetch(32'h308, 4'd6);
        drive(1, 32'h310, 1, 0, 0, 0, 0, 4'd7, 0, 0);
        ret(4'd5, 64'h5555);
        ret(4'd6, 64'h6666);
        fetch(32'h400, 4'd12);
        ret(4'd12, 64'hCCCC);
        // Stores allocate nothing; a rejected load retries.
        drive(0, 0, 0, 1, 2'd2, 32'h3000, 64'h0123_4567_89AB_CDEF, 4'd7, 0, 0);
        ret(4'd7, 64'h7777);
        drive(0, 0, 0, 1, 2'd1, 32'h3008, 0, 4'd0, 0, 0);
        drive(0, 0, 0, 1, 2'd1, 32'h3008, 0, 4'd13, 0, 0);
        ret(4'd13, 64'hDDDD);
        // Same-cycle return and reallocation of tag 9.
        drive(0, 0, 0, 1, 2'd1, 32'h3010, 0, 4'd9, 0, 0);
        drive(1, 32'h500, 0, 0, 0, 0, 0, 4'd9, 4'd9, 64'h9999_0001);
        ret(4'd9, 64'h9999_0002);
        // Random traffic, with a reset dropped in mid-stream.
        for (int i = 0; i < 700; i++) begin
            if (i == 350) do_reset(2);
            drive($urandom_range(0, 9) < 7, {$urandom} & 32'hFFFF_FFF8, $urandom_range(0, 19) == 0,
                  1'($urandom), $urandom_range(0, 1) ? 2'd1 : 2'd2, $urandom, {$urandom, $urandom},
                  $urandom_range(0, 4) == 0 ? 4'd0 : 4'($urandom_range(1, 15)),
                  $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)), {$urandom, $urandom});
        end
        idle();
        @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
